// File: rtl/dino_pkg.sv
// Shared types and constants for the dinosaur runner.
// Game states and BCD score limits.
package dino_pkg;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_RUN  = 2'd1,
        GS_OVER = 2'd2
    } gs_t;

    localparam int          SCORE_W   = 16;
    localparam logic [15:0] SCORE_MAX = 16'h9999;

endpackage

// File: rtl/bcd_inc.sv
// Four-digit BCD incrementer with saturation.
// Holds at 9999 and flags it instead of wrapping.
module bcd_inc
    import dino_pkg::*;
(
    input  logic [SCORE_W-1:0] i_val,
    output logic [SCORE_W-1:0] o_val,
    output logic               o_sat
);

    logic w_carry;

    // Ripple a +1 carry from the least significant digit upward
    always_comb begin
        o_sat   = (i_val == SCORE_MAX);
        o_val   = i_val;
        w_carry = ~o_sat;
        for (int d = 0; d < 4; d++) begin
            if (w_carry) begin
                if (i_val[4*d +: 4] == 4'd9) begin
                    o_val[4*d +: 4] = 4'd0;
                end else begin
                    o_val[4*d +: 4] = i_val[4*d +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: IDLE/RUN/OVER, collision latch,
// per-frame BCD scoring and best-score tracking.
module game_ctrl
    import dino_pkg::*;
#(
    parameter int FRAMES_PER_POINT = 6,
    parameter int SCORE_DIGITS     = 4
) (
    input  logic                      clk,
    input  logic                      RESET_n,
    input  logic                      fresh,
    input  logic                      START,
    input  logic                      dino_px,
    input  logic                      obstacle_px,
    output logic                      game_status,
    output logic                      game_over,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [4*SCORE_DIGITS-1:0] hi_score
);

    localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_POINT - 1);

    gs_t                r_state;
    gs_t                w_state_nxt;
    logic               r_s1;
    logic               r_s2;
    logic               r_s3;
    logic               r_fresh_d;
    logic               r_hit;
    logic               w_hit_nxt;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [SCORE_W-1:0] r_hi;
    logic [SCORE_W-1:0] w_hi_nxt;
    logic [SCORE_W-1:0] w_score_inc;
    logic               w_sat;
    logic               r_status;
    logic               r_over;
    logic               w_start_rise;
    logic               w_frame_end;
    logic               w_px;

    assign w_start_rise = r_s2 & ~r_s3;
    assign w_frame_end  = r_fresh_d & ~fresh;
    assign w_px         = dino_px & obstacle_px;

    bcd_inc u_inc (
        .i_val (r_score),
        .o_val (w_score_inc),
        .o_sat (w_sat)
    );

    // START synchronizer and frame-tick edge detector
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_fresh_d <= 1'b0;
        end else begin
            r_s1      <= START;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_fresh_d <= fresh;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state  <= GS_IDLE;
            r_hit    <= 1'b0;
            r_cnt    <= 8'd0;
            r_score  <= '0;
            r_hi     <= '0;
            r_status <= 1'b0;
            r_over   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hit    <= w_hit_nxt;
            r_cnt    <= w_cnt_nxt;
            r_score  <= w_score_nxt;
            r_hi     <= w_hi_nxt;
            r_status <= (w_state_nxt == GS_RUN);
            r_over   <= (w_state_nxt == GS_OVER);
        end
    end

    // Next state: start wins outside RUN, OVER beats a score step
    always_comb begin
        w_state_nxt = r_state;
        w_hit_nxt   = r_hit;
        w_cnt_nxt   = r_cnt;
        w_score_nxt = r_score;
        w_hi_nxt    = r_hi;
        unique case (r_state)
            GS_IDLE, GS_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt = GS_RUN;
                    w_hit_nxt   = 1'b0;
                    w_cnt_nxt   = 8'd0;
                    w_score_nxt = '0;
                end
            end
            GS_RUN: begin
                if (w_frame_end) begin
                    if (r_hit | w_px) begin
                        w_state_nxt = GS_OVER;
                        if (r_score > r_hi) begin
                            w_hi_nxt = r_score;
                        end
                    end else begin
                        w_hit_nxt = 1'b0;
                        if (r_cnt == CNT_LAST) begin
                            w_cnt_nxt   = 8'd0;
                            w_score_nxt = w_score_inc;
                        end else begin
                            w_cnt_nxt = r_cnt + 8'd1;
                        end
                    end
                end else if (w_px) begin
                    w_hit_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = GS_IDLE;
            end
        endcase
    end

    assign game_status = r_status;
    assign game_over   = r_over;
    assign score       = r_score;
    assign hi_score    = r_hi;

endmodule
